// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbitration types: result packet, per-FU request/grant bundles.
// Sizes and helpers used by the arbiter and its rotating multi-grant picker.
package cdb_arbiter_pkg;

  localparam int NUM_FU_ALU    = 3;
  localparam int NUM_FU_MULT   = 1;
  localparam int NUM_FU_BRANCH = 1;
  localparam int NUM_FU_MEM    = 1;
  localparam int NUM_CDB       = 3;
  localparam int NUM_REQ       = NUM_FU_ALU + NUM_FU_MULT
                               + NUM_FU_BRANCH + NUM_FU_MEM;
  localparam int PTR_W         = $clog2(NUM_REQ);

  localparam int MULT_BASE   = NUM_FU_ALU;
  localparam int BRANCH_BASE = MULT_BASE + NUM_FU_MULT;
  localparam int MEM_BASE    = BRANCH_BASE + NUM_FU_BRANCH;

  typedef logic [5:0]  PHYS_TAG;
  typedef logic [31:0] DATA;
  typedef logic [4:0]  ROB_IDX;

  typedef struct packed {
    logic    valid;
    PHYS_TAG tag;
    DATA     data;
    ROB_IDX  rob_idx;
  } CDB_PACKET;

  typedef struct packed {
    logic [NUM_FU_MEM-1:0]    mem;
    logic [NUM_FU_BRANCH-1:0] branch;
    logic [NUM_FU_MULT-1:0]   mult;
    logic [NUM_FU_ALU-1:0]    alu;
  } FU_REQUESTS;

  typedef FU_REQUESTS FU_GRANTS;

  // Flat index order: alu, mult, branch, mem (alu[0] is bit 0).
  function automatic logic [NUM_REQ-1:0] flatten(FU_REQUESTS r);
    return {r.mem, r.branch, r.mult, r.alu};
  endfunction

  function automatic FU_GRANTS unflatten(logic [NUM_REQ-1:0] f);
    FU_GRANTS g;
    g.alu    = f[NUM_FU_ALU-1:0];
    g.mult   = f[BRANCH_BASE-1:MULT_BASE];
    g.branch = f[MEM_BASE-1:BRANCH_BASE];
    g.mem    = f[NUM_REQ-1:MEM_BASE];
    return g;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Rotating-priority picker: grants the first NUM_GRANTS requesters found
// scanning upward (with wrap) from start, one-hot select per slot.
module rr_multi_grant #(
  parameter int NUM_REQ    = 6,
  parameter int NUM_GRANTS = 3,
  localparam int PW = $clog2(NUM_REQ),
  localparam int SW = (NUM_GRANTS > 1) ? $clog2(NUM_GRANTS) : 1
) (
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [PW-1:0]                       start,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_GRANTS-1:0][NUM_REQ-1:0]  sel,
  output logic [PW-1:0]                       last
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic [SW-1:0] slot;
  int            n;

  always_comb begin
    grant = '0;
    sel   = '0;
    last  = start;
    sum   = '0;
    idx   = '0;
    slot  = '0;
    n     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, start} + (PW+1)'(off);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (req[idx] && n < NUM_GRANTS) begin
        slot           = SW'(n);
        grant[idx]     = 1'b1;
        sel[slot][idx] = 1'b1;
        last           = idx;
        n              = n + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: rotating multi-grant over all FU results, registered broadcast.
// Optional CDB_PERF_EN adds denied-request and full-cycle counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mispredict,
  input  FU_REQUESTS                    fu_requests,
  input  CDB_PACKET [NUM_REQ-1:0]       fu_payloads,
  output FU_GRANTS                      fu_grants,
  output CDB_PACKET [NUM_CDB-1:0]       cdb_out,
  output logic [PTR_W-1:0]              rr_ptr_dbg
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]                   perf_denied,
  output logic [31:0]                   perf_full_cycles
`endif
);

  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               grant;
  logic [NUM_CDB-1:0][NUM_REQ-1:0]  sel;
  logic [PTR_W-1:0]                 last;
  logic [PTR_W-1:0]                 rr_ptr;
  CDB_PACKET [NUM_CDB-1:0]          slot_pkt;

  // Flush and reset suppress every grant, which also freezes the pointer.
  assign req = (reset || mispredict) ? '0 : flatten(fu_requests);

  rr_multi_grant #(
    .NUM_REQ    (NUM_REQ),
    .NUM_GRANTS (NUM_CDB)
  ) u_pick (
    .req   (req),
    .start (rr_ptr),
    .grant (grant),
    .sel   (sel),
    .last  (last)
  );

  assign fu_grants  = unflatten(grant);
  assign rr_ptr_dbg = rr_ptr;

  always_comb begin
    slot_pkt = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (sel[k][i])
          slot_pkt[k] = slot_pkt[k] | fu_payloads[i];
      if (|sel[k])
        slot_pkt[k].valid = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || mispredict)
      cdb_out <= '0;
    else
      cdb_out <= slot_pkt;
  end

  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (|grant)
      rr_ptr <= (last == PTR_W'(NUM_REQ-1)) ? '0 : last + 1'b1;
  end

`ifdef CDB_PERF_EN
  logic [31:0] denied_now;
  logic [32:0] denied_sum;
  logic        full_now;

  assign denied_now = 32'($countones(req & ~grant));
  assign denied_sum = {1'b0, perf_denied} + {1'b0, denied_now};
  assign full_now   = ($countones(grant) == NUM_CDB);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_denied      <= '0;
      perf_full_cycles <= '0;
    end else begin
      perf_denied <= denied_sum[32] ? '1 : denied_sum[31:0];
      if (full_now && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Responder side of the FU_REQUESTS/FU_GRANTS handshake. Each cycle it collects CDB requests from every functional unit (ALU and branch requests from issue, mult and mem requests from execute) and grants up to NUM_CDB of them using rotating priority. It registers the winners' result packets onto the common data bus, one cycle after the grant, for RS wakeup, map table, and ROB completion.

Parameters:
NUM_CDB, `NUM_CDB (default 3), number of broadcast slots per cycle
NUM_REQ, `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_BRANCH+`NUM_FU_MEM (default 6), flattened requester count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
mispredict  in  1  branch recovery flush
fu_requests  in  FU_REQUESTS  per-FU request bits
fu_payloads  in  CDB_PACKET[NUM_REQ]  result packets {valid, tag PHYS_TAG, data DATA, rob_idx ROB_IDX}, flat order
fu_grants  out  FU_GRANTS  same-cycle grant bits, same structure as fu_requests
cdb_out  out  CDB_PACKET[NUM_CDB]  registered broadcast slots
rr_ptr_dbg  out  clog2(NUM_REQ)  current priority pointer

Behaviour:
- Flat index order: alu[0..], then mult[0..], then branch[0..], then mem[0..]; fu_payloads uses the same order.
- Grants are combinational from fu_requests and rr_ptr, with zero added latency. The requester must hold its request and payload until it sees its grant bit.
- Scan starts at rr_ptr and increments modulo NUM_REQ (wraps NUM_REQ-1 -> 0). The first NUM_CDB requesting indices are granted.
- Grant guarantees:
  - grant is a subset of request;
  - popcount(grant) <= NUM_CDB;
  - every request is granted when popcount(request) <= NUM_CDB.
- Slot assignment: the k-th grant in scan order goes to slot k. Slots beyond the number of grants are 0.
- Broadcast register: cdb_out[k] <= granted payload, with valid forced to 1. Unused slots <= '0. Broadcast happens exactly 1 cycle after the grant.
- rr_ptr update:
  - if any grant: rr_ptr <= (last granted index + 1) mod NUM_REQ;
  - if no grant: rr_ptr holds.
  - This guarantees bounded wait of ceil(NUM_REQ/NUM_CDB) cycles for a held request.
- mispredict:
  - fu_grants forced to 0 in that cycle;
  - cdb_out <= '0 next edge;
  - rr_ptr holds.
  - Entries already in cdb_out during the mispredict cycle remain visible for that cycle.
- reset:
  - fu_grants forced to 0 while reset is high;
  - cdb_out <= '0; rr_ptr <= 0; rr_ptr_dbg = 0.
- Mispredict and reset together behave as reset.
- Payload valid=0 on a requested index: still granted, broadcast with valid=1. This is the requester's error; the bench flags it with an assertion.

Optional Feature:
CDB_PERF_EN:
- When defined, adds ports:
  - perf_denied out 32, saturating count of requests not granted per cycle, accumulated (adds popcount(req & ~grant) each cycle);
  - perf_full_cycles out 32, cycles with popcount(grant)==NUM_CDB.
- Both counters reset to 0 on reset and hold on mispredict.
- When not defined, the ports and counters are absent and the logic is identical otherwise.

Decomposition:
- Shared package (sys_defs.svh):
  - CDB_PACKET, FU_REQUESTS, FU_GRANTS;
  - `NUM_CDB and the `NUM_FU_* constants;
  - PHYS_TAG, DATA, ROB_IDX.
- Sub-module rr_multi_grant (NUM_REQ, NUM_GRANTS):
  - inputs: req vector and start pointer;
  - outputs: grant vector, per-slot one-hot selects [NUM_GRANTS][NUM_REQ], and last-granted index.
- The top level handles flattening/unflattening, the broadcast register, and the pointer register.

Test Plan:
All scenarios use the default configuration, ALU=3/MULT=1/BRANCH=1/MEM=1, NUM_CDB=3.
- Reset: hold reset 2 cycles with all requests high -> fu_grants=0, cdb_out all valid=0, rr_ptr_dbg=0. Release -> grants at idx 0,1,2 (alu0-2). Next cycle cdb_out[0..2] carry their tags; rr_ptr=3.
- Under-subscription: only mult0 (idx 3, tag 17, data 0x2A) and mem0 (idx 5) request, rr_ptr=0 -> both granted. Next cycle cdb_out[0]={tag 17, 0x2A}, cdb_out[1]=mem0 payload, cdb_out[2].valid=0; rr_ptr=0.
- Wrap: all 6 requesting, rr_ptr=4 -> grants idx 4, 5, 0 (branch0, mem0, alu0) in slots 0,1,2; rr_ptr becomes 1.
- Fairness: all 6 held for 4 cycles, with a requester's bit dropped once granted -> every index granted within 2 cycles; no grant exceeds 3 per cycle.
- Mispredict: all requesting, mispredict=1 in cycle N -> fu_grants=0 in N; cdb_out all valid=0 in N+1; rr_ptr unchanged. Cycle N+1 grants resume from the same pointer.
- CDB_PERF_EN: 3 cycles with all 6 requesting -> perf_denied=9, perf_full_cycles=3. Reset -> both 0.
